// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage byte-lane data RAM with registered RV32I loads; DMEM_MISALIGN_TRAP_EN enables misalignment trapping
module dmem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_MemRead,
  input  logic        Mem_MemWrite,
  input  logic [2:0]  Mem_Funct3,
  input  logic [31:0] Mem_ALUResult,
  input  logic [31:0] Mux_Mem_WriteData,
  input  logic        Mem_Stall,
  output logic [31:0] Wb_Mem_ReadData,
  output logic        Wb_Mem_ReadValid,
  output logic        Mem_Misaligned
);
  logic [31:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] off, off_e;
  logic is_b, is_h, is_w, legal, misal, we, rd_ok;
  logic [3:0] be;
  logic [31:0] wdata, word, sh, ext;
  logic unused_addr;
  assign unused_addr = ^{Mem_ALUResult[31:ADDR_BITS+2]};
  assign idx   = Mem_ALUResult[ADDR_BITS+1:2];
  assign off   = Mem_ALUResult[1:0];
  assign is_b  = Mem_Funct3[1:0] == 2'b00;
  assign is_h  = Mem_Funct3[1:0] == 2'b01;
  assign is_w  = Mem_Funct3 == 3'b010;
  assign legal = is_w || (Mem_Funct3[1] == 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign off_e = off;
  assign misal = legal && ((is_h && off[0]) || (is_w && off != 2'b00));
`else
  assign off_e = is_w ? 2'b00 : is_h ? {off[1], 1'b0} : off;
  assign misal = 1'b0;
`endif
  // lane enables and lane-replicated store data
  always_comb begin
    be    = is_w ? 4'hf : is_h ? (4'b0011 << off_e) : (4'b0001 << off_e);
    wdata = is_w ? Mux_Mem_WriteData : is_h ? {2{Mux_Mem_WriteData[15:0]}} : {4{Mux_Mem_WriteData[7:0]}};
    we    = !rst && !Mem_Stall && Mem_MemWrite && legal && !misal;
    rd_ok = Mem_MemRead && !Mem_MemWrite && legal && !misal;
    word  = mem[idx];
    sh    = word >> {off_e, 3'b000};
    ext   = is_w ? word
          : is_h ? {{16{sh[15] && !Mem_Funct3[2]}}, sh[15:0]}
          : is_b ? {{24{sh[7] && !Mem_Funct3[2]}}, sh[7:0]} : 32'h0;
  end
  // byte-lane RAM write; contents survive reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  // registered load result, valid flag and misalignment flag
  always_ff @(posedge clk) begin
    if (rst) begin
      Wb_Mem_ReadData  <= 32'h0;
      Wb_Mem_ReadValid <= 1'b0;
      Mem_Misaligned   <= 1'b0;
    end else if (!Mem_Stall) begin
      Wb_Mem_ReadValid <= rd_ok;
      Mem_Misaligned   <= (Mem_MemRead || Mem_MemWrite) && misal;
      if (Mem_MemRead && !Mem_MemWrite) Wb_Mem_ReadData <= rd_ok ? ext : 32'h0;
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench for dmem_access_unit
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, stall = 1'b0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] addr = 32'h0, wd = 32'h0;
  logic [31:0] rdata;
  logic        rvalid, mis;
  int checks = 0, failures = 0;
  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;
  always #5 clk = ~clk;
  dmem_access_unit #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst), .Mem_MemRead(rd), .Mem_MemWrite(wr), .Mem_Funct3(f3),
    .Mem_ALUResult(addr), .Mux_Mem_WriteData(wd), .Mem_Stall(stall),
    .Wb_Mem_ReadData(rdata), .Wb_Mem_ReadValid(rvalid), .Mem_Misaligned(mis)
  );
  task automatic req(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; f3 = f; addr = a; wd = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    req(1'b0, 1'b0, FW, 32'h0, 32'h0);
  endtask
  task automatic test_reset();
    rst = 1'b1; req(1'b0, 1'b1, FW, 32'h10, 32'h1111_1111);
    step(); step();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b0 || mis !== 1'b0) begin failures++; $display("FAIL reset_init data=%h valid=%b mis=%b expected 0/0/0", rdata, rvalid, mis); end
    rst = 1'b0; req(1'b0, 1'b1, FW, 32'h10, 32'hCAFE_F00D); step();
    rst = 1'b1; req(1'b0, 1'b1, FW, 32'h10, 32'hFFFF_FFFF); step(); step();
    rst = 1'b0; req(1'b1, 1'b0, FW, 32'h10, 32'h0); step();
    checks++; if (rdata !== 32'hCAFE_F00D || rvalid !== 1'b1) begin failures++; $display("FAIL reset_store_suppressed data=%h valid=%b expected cafef00d/1", rdata, rvalid); end
    rst = 1'b1; stall = 1'b1; step();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b0) begin failures++; $display("FAIL reset_over_stall data=%h valid=%b expected 0/0", rdata, rvalid); end
    stall = 1'b0; req(1'b1, 1'b0, FW, 32'h10, 32'h0); step();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b0) begin failures++; $display("FAIL reset_discards_load data=%h valid=%b expected 0/0", rdata, rvalid); end
    rst = 1'b0; idle();
  endtask
  task automatic test_extend();
    logic [2:0]  fs [11] = '{FB, FB, FB, FB, FBU, FBU, FH, FH, FHU, FHU, FW};
    logic [31:0] as [11] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h23, 32'h22, 32'h20, 32'h22, 32'h22, 32'h20, 32'h20};
    logic [31:0] es [11] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_00FF,
                             32'h0000_7F01, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    req(1'b0, 1'b1, FW, 32'h20, 32'h80FF_7F01); step();
    for (int i = 0; i < 11; i++) begin
      req(1'b1, 1'b0, fs[i], as[i], 32'h0); step();
      checks++; if (rdata !== es[i] || rvalid !== 1'b1) begin failures++; $display("FAIL extend_%0d f3=%b addr=%h data=%h valid=%b expected %h/1", i, fs[i], as[i], rdata, rvalid, es[i]); end
    end
    idle(); step();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h80FF_7F01) begin failures++; $display("FAIL idle_hold data=%h valid=%b expected 80ff7f01/0", rdata, rvalid); end
  endtask
  task automatic test_byte_store();
    req(1'b0, 1'b1, FW, 32'h20, 32'h1122_3344); step();
    req(1'b0, 1'b1, FB, 32'h21, 32'hFFFF_FFAA); step();
    req(1'b1, 1'b0, FW, 32'h20, 32'h0); step();
    checks++; if (rdata !== 32'h1122_AA44) begin failures++; $display("FAIL sb_merge data=%h expected 1122aa44", rdata); end
    req(1'b0, 1'b1, FH, 32'h22, 32'h0000_BEEF); step();
    req(1'b1, 1'b0, FW, 32'h20, 32'h0); step();
    checks++; if (rdata !== 32'hBEEF_AA44) begin failures++; $display("FAIL sh_merge data=%h expected beefaa44", rdata); end
    req(1'b1, 1'b0, FW, 32'h1020, 32'h0); step();
    checks++; if (rdata !== 32'hBEEF_AA44) begin failures++; $display("FAIL alias data=%h expected beefaa44", rdata); end
    idle();
  endtask
  task automatic test_stall();
    req(1'b0, 1'b1, FW, 32'h40, 32'h0102_0304); step();
    req(1'b1, 1'b0, FW, 32'h20, 32'h0); step();
    stall = 1'b1; req(1'b0, 1'b1, FW, 32'h40, 32'hDEAD_BEEF); step(); step();
    checks++; if (rdata !== 32'hBEEF_AA44 || rvalid !== 1'b1) begin failures++; $display("FAIL stall_hold data=%h valid=%b expected beefaa44/1", rdata, rvalid); end
    stall = 1'b0; req(1'b1, 1'b0, FW, 32'h40, 32'h0); step();
    checks++; if (rdata !== 32'h0102_0304) begin failures++; $display("FAIL stall_no_write data=%h expected 01020304", rdata); end
    req(1'b0, 1'b1, FW, 32'h40, 32'hDEAD_BEEF); step();
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL store_valid valid=%b expected 0", rvalid); end
    req(1'b1, 1'b0, FW, 32'h40, 32'h0); step();
    checks++; if (rdata !== 32'hDEAD_BEEF || rvalid !== 1'b1) begin failures++; $display("FAIL stall_replay data=%h valid=%b expected deadbeef/1", rdata, rvalid); end
    idle();
  endtask
  task automatic test_rw_illegal();
    req(1'b1, 1'b1, FW, 32'h8, 32'h5); step();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_both data=%h valid=%b expected deadbeef/0", rdata, rvalid); end
    req(1'b0, 1'b1, 3'b110, 32'h8, 32'hFFFF_FFFF); step();
    req(1'b1, 1'b0, FW, 32'h8, 32'h0); step();
    checks++; if (rdata !== 32'h5 || rvalid !== 1'b1) begin failures++; $display("FAIL rw_word data=%h valid=%b expected 00000005/1", rdata, rvalid); end
    req(1'b1, 1'b0, 3'b011, 32'h8, 32'h0); step();
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b0) begin failures++; $display("FAIL illegal_load data=%h valid=%b expected 0/0", rdata, rvalid); end
    idle();
  endtask
  task automatic test_misalign();
    req(1'b0, 1'b1, FW, 32'h42, 32'h1234_5678); step();
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (mis !== 1'b1) begin failures++; $display("FAIL mis_set mis=%b expected 1", mis); end
    req(1'b1, 1'b0, FW, 32'h40, 32'h0); step();
    checks++; if (mis !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_store mis=%b data=%h expected 0/deadbeef", mis, rdata); end
    req(1'b1, 1'b0, FH, 32'h43, 32'h0); step();
    checks++; if (mis !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b0) begin failures++; $display("FAIL mis_load mis=%b data=%h valid=%b expected 1/0/0", mis, rdata, rvalid); end
`else
    checks++; if (mis !== 1'b0) begin failures++; $display("FAIL mis_tied mis=%b expected 0", mis); end
    req(1'b1, 1'b0, FW, 32'h40, 32'h0); step();
    checks++; if (mis !== 1'b0 || rdata !== 32'h1234_5678) begin failures++; $display("FAIL mis_store mis=%b data=%h expected 0/12345678", mis, rdata); end
    req(1'b1, 1'b0, FH, 32'h43, 32'h0); step();
    checks++; if (mis !== 1'b0 || rdata !== 32'h0000_1234 || rvalid !== 1'b1) begin failures++; $display("FAIL mis_load mis=%b data=%h valid=%b expected 0/00001234/1", mis, rdata, rvalid); end
`endif
    idle(); step();
    checks++; if (mis !== 1'b0) begin failures++; $display("FAIL mis_clear mis=%b expected 0", mis); end
  endtask
  initial begin
    test_reset();
    test_extend();
    test_byte_store();
    test_stall();
    test_rw_illegal();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
